ewb_drain_controller: RTL and testbench
=======================================

Name: ewb_drain_controller

Overview:
- Read-side partner of the L2 eviction write buffer (EWB).
- Watches the EWB's full flag and drains the held 256-bit dirty line to physical memory as a 4-beat, 64-bit write burst.
- Pulses the EWB's empty input when the burst completes.
- Owns the pmem write port; defers to pending L2 miss reads before a burst starts; never abandons a started burst.

Parameters:
- BEATS, 4, 64-bit beats per 256-bit line.
- HOLDOFF, 4, consecutive eligible cycles required before a drain starts (non-eager build only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ewb_full_i  in  1  EWB holds valid data
- ewb_wdata_i  in  256  line held by EWB
- ewb_address_i  in  32  line address held by EWB
- ewb_empty_o  out  1  one-cycle pulse; EWB clears on the following edge
- read_pending_i  in  1  L2 miss read wants the pmem port
- busy_o  out  1  drain burst in progress; read arbiter must wait
- pmem_write_o  out  1  write request
- pmem_address_o  out  32  line address, low 5 bits forced to 0
- pmem_burst_o  out  64  current beat data
- pmem_resp_i  in  1  beat accepted

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- All outputs and state are 0 under rst; FSM in IDLE; beat counter 0.
- FSM states and transitions:
  - IDLE -> HOLD when ewb_full_i & !read_pending_i.
  - HOLD: holdoff counter increments each cycle ewb_full_i & !read_pending_i.
    - Any cycle with read_pending_i=1 or ewb_full_i=0 returns to IDLE and clears the counter.
    - Counter reaching HOLDOFF-1 -> BURST.
  - BURST: pmem_write_o=1 and busy_o=1, both registered.
    - pmem_address_o = {ewb_address_i[31:5],5'b0}, latched on BURST entry.
    - pmem_burst_o = line_latched[64*beat +: 64]; line latched on BURST entry.
    - Each pmem_resp_i increments beat. On resp with beat==BEATS-1: beat wraps to 0, write deasserts, -> DONE.
  - DONE: ewb_empty_o=1 for exactly one cycle, busy_o=0 -> IDLE.
- Latency:
  - Non-eager: first write-asserted cycle is HOLDOFF+1 cycles after the first eligible cycle.
  - Eager: 1 cycle (see Optional Feature).
- Read priority: read_pending_i wins only before BURST. In BURST it is ignored; busy_o tells the arbiter to stall.
- Simultaneous events:
  - read_pending_i and ewb_full_i rising together in IDLE -> stay IDLE.
  - pmem_resp_i outside BURST is ignored.
- Data is latched at BURST entry, so ewb_full_i dropping mid-burst has no effect on the burst; it is still reported as a simulation assertion error.
- No re-drain: in the cycle after DONE, ewb_full_i is already 0 because the EWB clears synchronously.
- rst mid-burst: pmem_write_o drops immediately (asynchronously). A truncated pmem transaction is acceptable only at system reset.
- Line address bits [4:0] are always 0 on pmem_address_o.

Optional Feature:
- Macro: EWB_EAGER_DRAIN_EN.
- Defined: HOLD state is removed and HOLDOFF is unused. IDLE -> BURST on the first cycle with ewb_full_i & !read_pending_i.
- Undefined: HOLDOFF behaviour as above, which lets back-to-back miss reads pass a freshly loaded EWB.

Decomposition:
- Shared package l2_cache_pkg holds:
  - ewb_drain_state_t enum {IDLE, HOLD, BURST, DONE};
  - LINE_W=256, BURST_W=64, OFFSET_W=5 constants.
- One natural sub-module: ewb_beat_mux, the combinational 256->64 beat select indexed by the beat counter.
- Holdoff counter and FSM stay in the top module.

Test Plan:
- Basic drain:
  - Stimulus: ewb_full_i=1, address 0x0000_1234, line {64'hD,64'hC,64'hB,64'hA}, resp every cycle.
  - Response: after HOLDOFF, pmem_address_o=0x0000_1220; bursts A,B,C,D; one ewb_empty_o pulse; busy_o high exactly 4 cycles.
- Read priority:
  - Stimulus: read_pending_i=1 pulses every third cycle while full.
  - Response: no burst starts until HOLDOFF consecutive clear cycles; counter observed resetting.
- Burst not preempted:
  - Stimulus: read_pending_i=1 asserted on beat 1, resp delayed 3 cycles per beat.
  - Response: burst completes all 4 beats with data held stable between resps; busy_o stays 1.
- Async reset:
  - Stimulus: rst asserted mid-cycle during beat 2.
  - Response: pmem_write_o, busy_o, ewb_empty_o go 0 without a clock edge.
  - Post-reset drain restarts from beat 0.
- Back-to-back:
  - Stimulus: EWB reloaded the cycle after empty.
  - Response: second drain with new address; no duplicate empty pulse; no re-drain of the old line.
- EWB_EAGER_DRAIN_EN defined:
  - Stimulus: full asserted at cycle N.
  - Response: pmem_write_o=1 at N+1.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// Shared L2 cache definitions used by the eviction write buffer drain path.
//
// Contents:
//   ewb_drain_state_t  drain controller FSM states
//   LINE_W             width of one cache line (bits)
//   BURST_W            width of one pmem beat (bits)
//   OFFSET_W           byte-offset bits within a line, zeroed on pmem addresses
package l2_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    BURST,
    DONE
  } ewb_drain_state_t;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int OFFSET_W = 5;

endpackage

// File: rtl/ewb_beat_mux.sv
// Combinational beat select: picks the 64-bit slice of a latched line that
// corresponds to the current burst beat. Beat 0 is the least significant slice.
//
// Ports:
//   line_i       latched cache line
//   beat_i       current beat index
//   beat_data_o  selected beat data
module ewb_beat_mux
  import l2_cache_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic [BEATS*BURST_W-1:0] line_i,
  input  logic [$clog2(BEATS)-1:0] beat_i,
  output logic [BURST_W-1:0]       beat_data_o
);

  assign beat_data_o = line_i[beat_i*BURST_W +: BURST_W];

endmodule

// File: rtl/ewb_drain_controller.sv
// Read-side partner of the L2 eviction write buffer. Waits for the EWB to hold
// a dirty line, gives pending miss reads a chance at the pmem port, then
// writes the line out as a BEATS-long burst and pulses ewb_empty_o once.
// A started burst is never abandoned; busy_o stalls the read arbiter meanwhile.
//
// Configuration macro: EWB_EAGER_DRAIN_EN
//   undefined: the line must stay eligible through a HOLD window of HOLDOFF
//              cycles before the burst starts, letting back-to-back miss
//              reads slip past a freshly loaded EWB.
//   defined:   no HOLD window; the burst starts on the first eligible cycle.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ewb_full_i       EWB holds a valid line
//   ewb_wdata_i      line held by the EWB
//   ewb_address_i    line address held by the EWB
//   ewb_empty_o      one-cycle pulse telling the EWB to clear
//   read_pending_i   an L2 miss read wants the pmem port
//   busy_o           drain burst in progress
//   pmem_write_o     pmem write request
//   pmem_address_o   line-aligned pmem address
//   pmem_burst_o     current beat data
//   pmem_resp_i      pmem accepted the current beat
module ewb_drain_controller
  import l2_cache_pkg::*;
#(
  parameter int BEATS   = 4,
  parameter int HOLDOFF = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ewb_full_i,
  input  logic [LINE_W-1:0]   ewb_wdata_i,
  input  logic [31:0]         ewb_address_i,
  output logic                ewb_empty_o,
  input  logic                read_pending_i,
  output logic                busy_o,
  output logic                pmem_write_o,
  output logic [31:0]         pmem_address_o,
  output logic [BURST_W-1:0]  pmem_burst_o,
  input  logic                pmem_resp_i
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  ewb_drain_state_t       state_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   write_q;
  logic                   busy_q;
  logic                   empty_q;
  logic [31:OFFSET_W]     addr_q;
  logic [LINE_W-1:0]      line_q;
`ifndef EWB_EAGER_DRAIN_EN
  logic [HOLD_W-1:0]      hold_q;
`endif

  // The low offset bits never reach pmem; HOLDOFF only matters without the
  // eager build. Both are folded here so they are visibly intentional.
  logic unusedBits;
  assign unusedBits = ^{ewb_address_i[OFFSET_W-1:0], HOLDOFF[0]};

  logic eligible;
  assign eligible = ewb_full_i & ~read_pending_i;

  // Drain FSM with registered outputs. Entering BURST snapshots the line and
  // address so the EWB contents may change without disturbing the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      empty_q <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
`ifndef EWB_EAGER_DRAIN_EN
      hold_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (eligible) begin
`ifdef EWB_EAGER_DRAIN_EN
            state_q <= BURST;
            beat_q  <= '0;
            write_q <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= ewb_address_i[31:OFFSET_W];
            line_q  <= ewb_wdata_i;
`else
            state_q <= HOLD;
            hold_q  <= '0;
`endif
          end
        end
`ifndef EWB_EAGER_DRAIN_EN
        // Any read request or a vanished line restarts the holdoff window.
        HOLD: begin
          if (!eligible) begin
            state_q <= IDLE;
            hold_q  <= '0;
          end else if (hold_q == HOLD_W'(HOLDOFF - 1)) begin
            state_q <= BURST;
            hold_q  <= '0;
            beat_q  <= '0;
            write_q <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= ewb_address_i[31:OFFSET_W];
            line_q  <= ewb_wdata_i;
          end else begin
            hold_q  <= hold_q + 1'b1;
          end
        end
`endif
        // read_pending_i is deliberately ignored here; busy_o stalls reads.
        BURST: begin
          if (pmem_resp_i) begin
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              state_q <= DONE;
              beat_q  <= '0;
              write_q <= 1'b0;
              busy_q  <= 1'b0;
              empty_q <= 1'b1;
            end else begin
              beat_q  <= beat_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          empty_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  ewb_beat_mux #(
    .BEATS(BEATS)
  ) u_beat_mux (
    .line_i      (line_q),
    .beat_i      (beat_q),
    .beat_data_o (pmem_burst_o)
  );

  assign pmem_write_o   = write_q;
  assign busy_o         = busy_q;
  assign ewb_empty_o    = empty_q;
  assign pmem_address_o = {addr_q, {OFFSET_W{1'b0}}};

  // The burst runs from its snapshot, but the EWB dropping its line mid-burst
  // means some other agent broke the handshake.
  ewbFullHeldInBurst: assert property (
    @(posedge clk) disable iff (rst) (state_q == BURST) |-> ewb_full_i
  ) else $error("ewb_full_i dropped during a drain burst");

endmodule

// File: tb/tb_ewb_drain_controller.sv
// Self-checking bench for ewb_drain_controller: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_ewb_drain_controller;

  localparam int BEATS   = 4;
  localparam int HOLDOFF = 4;
`ifdef EWB_EAGER_DRAIN_EN
  localparam int START_STREAK = 1;
`else
  localparam int START_STREAK = HOLDOFF + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         ewbFull;
  logic [255:0] ewbData;
  logic [31:0]  ewbAddr;
  logic         readPending;
  logic         pmemResp;
  logic         ewb_empty_o;
  logic         busy_o;
  logic         pmem_write_o;
  logic [31:0]  pmem_address_o;
  logic [63:0]  pmem_burst_o;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;
  bit prevEmpty;

  always #5 clk = ~clk;

  ewb_drain_controller #(
    .BEATS  (BEATS),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ewb_full_i     (ewbFull),
    .ewb_wdata_i    (ewbData),
    .ewb_address_i  (ewbAddr),
    .ewb_empty_o    (ewb_empty_o),
    .read_pending_i (readPending),
    .busy_o         (busy_o),
    .pmem_write_o   (pmem_write_o),
    .pmem_address_o (pmem_address_o),
    .pmem_burst_o   (pmem_burst_o),
    .pmem_resp_i    (pmemResp)
  );

  // Single checking task: counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model: a drain starts once the line has been eligible for
  // START_STREAK consecutive cycles, then advances one beat per response,
  // then spends one cycle announcing empty.
  bit           mBusy   = 1'b0;
  bit           mEmpty  = 1'b0;
  int           mBeat   = 0;
  int           mStreak = 0;
  logic [31:0]  mAddr   = '0;
  logic [255:0] mLine   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy = 0; mEmpty = 0; mBeat = 0; mStreak = 0; mAddr = '0; mLine = '0;
    end else if (mBusy) begin
      if (pmemResp) begin
        mBeat++;
        if (mBeat == BEATS) begin
          mBusy  = 0;
          mBeat  = 0;
          mEmpty = 1;
        end
      end
    end else if (mEmpty) begin
      mEmpty  = 0;
      mStreak = 0;
    end else if (ewbFull && !readPending) begin
      mStreak++;
      if (mStreak == START_STREAK) begin
        mBusy   = 1;
        mStreak = 0;
        mBeat   = 0;
        mAddr   = ewbAddr & 32'hFFFF_FFE0;
        mLine   = ewbData;
      end
    end else begin
      mStreak = 0;
    end
  end

  // Continuous comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (checkEn && !rst) begin
      checkOutput("write", 64'(pmem_write_o), 64'(mBusy));
      checkOutput("busy",  64'(busy_o),       64'(mBusy));
      checkOutput("empty", 64'(ewb_empty_o),  64'(mEmpty));
      checkOutput("addr",  64'(pmem_address_o), 64'(mAddr));
      checkOutput("burst", pmem_burst_o, mLine[64*mBeat +: 64]);
    end
  end

  function automatic logic [255:0] randLine();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One cycle of stimulus, driven at the falling edge. Behaves like the EWB:
  // the line clears on the edge after an empty pulse and can be reloaded.
  task automatic driveCycle(input bit wantLoad, input bit rp, input bit resp,
                            input logic [31:0] addr, input logic [255:0] data,
                            output bit loaded);
    @(negedge clk);
    loaded = 1'b0;
    if (prevEmpty) ewbFull = 1'b0;
    prevEmpty = ewb_empty_o;
    if (!ewbFull && wantLoad) begin
      ewbFull = 1'b1;
      ewbData = data;
      ewbAddr = addr;
      loaded  = 1'b1;
    end
    readPending = rp;
    pmemResp    = resp;
  endtask

  task automatic applyStimulus(input int n, input int loadPct, input int readPct,
                               input int respPct);
    bit ld;
    for (int i = 0; i < n; i++) begin
      driveCycle($urandom_range(99) < loadPct, $urandom_range(99) < readPct,
                 $urandom_range(99) < respPct, $urandom, randLine(), ld);
    end
  endtask

  logic [255:0] basicLine;
  logic [255:0] lineA;
  logic [255:0] lineB;
  logic [63:0]  beatQ[$];
  logic [31:0]  addrQ[$];
  int           lat;
  int           busyCnt;
  int           emptyCnt;
  int           reloads;
  bit           ld;
  bit           found;
  bit           gotFirst;
  bit           prevWrite;

  initial begin
    rst = 1'b1; ewbFull = 1'b0; ewbData = '0; ewbAddr = '0;
    readPending = 1'b0; pmemResp = 1'b0; prevEmpty = 1'b0;
    basicLine = {64'hD, 64'hC, 64'hB, 64'hA};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstWrite", 64'(pmem_write_o), 64'd0);
    checkOutput("rstBusy",  64'(busy_o),       64'd0);
    checkOutput("rstEmpty", 64'(ewb_empty_o),  64'd0);
    checkOutput("rstAddr",  64'(pmem_address_o), 64'd0);
    checkOutput("rstBurst", pmem_burst_o,      64'd0);
    rst = 1'b0;
    checkEn = 1'b1;

    // Basic drain with response every cycle
    repeat (2) driveCycle(0, 0, 1, '0, '0, ld);
    driveCycle(1, 0, 1, 32'h0000_1234, basicLine, ld);
    lat = 0; busyCnt = 0; emptyCnt = 0; beatQ.delete();
    for (int k = 1; k <= 30; k++) begin
      driveCycle(0, 0, 1, '0, '0, ld);
      if (pmem_write_o && lat == 0) begin
        lat = k;
        checkOutput("basicAddr", 64'(pmem_address_o), 64'h1220);
      end
      if (busy_o) begin
        busyCnt++;
        beatQ.push_back(pmem_burst_o);
      end
      if (ewb_empty_o) emptyCnt++;
    end
    checkOutput("basicLatency", 64'(lat), 64'(START_STREAK));
    checkOutput("basicBusyCycles", 64'(busyCnt), 64'd4);
    checkOutput("basicEmptyPulses", 64'(emptyCnt), 64'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("basicBeat%0d", i),
                  (beatQ.size() > i) ? beatQ[i] : 64'hx, basicLine[64*i +: 64]);
    end

    // Read priority: a read every third cycle keeps the holdoff from expiring
    lineA = randLine();
    driveCycle(1, 1, 0, 32'h0000_4440, lineA, ld);
    busyCnt = 0; emptyCnt = 0;
    for (int k = 1; k <= 30; k++) begin
      driveCycle(0, (k % 3) == 0, 0, '0, '0, ld);
      if (busy_o) busyCnt++;
      if (ewb_empty_o) emptyCnt++;
    end
`ifndef EWB_EAGER_DRAIN_EN
    checkOutput("prioNoBurst", 64'(busyCnt), 64'd0);
`endif
    for (int k = 1; k <= 20; k++) begin
      driveCycle(0, 0, 1, '0, '0, ld);
      if (ewb_empty_o) emptyCnt++;
    end
    checkOutput("prioDrained", 64'(emptyCnt), 64'd1);

    // Burst not preempted: reads pending from beat 1, slow responses
    lineA = randLine();
    driveCycle(1, 0, 0, 32'h0BAD_F00D, lineA, ld);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      driveCycle(0, 0, 0, '0, '0, ld);
      if (busy_o) found = 1'b1;
    end
    checkOutput("npStart", 64'(found), 64'd1);
    busyCnt = 1; emptyCnt = 0;
    for (int j = 1; j <= 40; j++) begin
      driveCycle(0, j >= 3, (j % 3) == 2, '0, '0, ld);
      if (busy_o) busyCnt++;
      if (ewb_empty_o) emptyCnt++;
      if (!busy_o) break;
    end
    checkOutput("npBusyCycles", 64'(busyCnt), 64'd12);
    checkOutput("npEmptyPulse", 64'(emptyCnt), 64'd1);
    repeat (3) driveCycle(0, 0, 0, '0, '0, ld);

    // Asynchronous reset during beat 2, then a fresh drain from beat 0
    lineB = randLine();
    driveCycle(1, 0, 0, 32'h7654_3210, lineB, ld);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      driveCycle(0, 0, 0, '0, '0, ld);
      if (busy_o) found = 1'b1;
    end
    checkOutput("arStart", 64'(found), 64'd1);
    driveCycle(0, 0, 1, '0, '0, ld);
    driveCycle(0, 0, 1, '0, '0, ld);
    driveCycle(0, 0, 0, '0, '0, ld);
    checkOutput("arBeat2", pmem_burst_o, lineB[128 +: 64]);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arWriteDrop", 64'(pmem_write_o), 64'd0);
    checkOutput("arBusyDrop",  64'(busy_o),       64'd0);
    checkOutput("arEmptyLow",  64'(ewb_empty_o),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    gotFirst = 1'b0; emptyCnt = 0;
    for (int k = 0; k < 30; k++) begin
      driveCycle(0, 0, 1, '0, '0, ld);
      if (busy_o && !gotFirst) begin
        gotFirst = 1'b1;
        checkOutput("arRestartBeat0", pmem_burst_o, lineB[63:0]);
        checkOutput("arRestartAddr", 64'(pmem_address_o), 64'h7654_3200);
      end
      if (ewb_empty_o) emptyCnt++;
    end
    checkOutput("arRestartSeen", 64'(gotFirst), 64'd1);
    checkOutput("arRestartDone", 64'(emptyCnt), 64'd1);

    // Back-to-back: EWB reloaded the cycle after the empty pulse
    lineA = randLine();
    lineB = randLine();
    driveCycle(1, 0, 1, 32'hABCD_0047, lineA, ld);
    reloads = 0; emptyCnt = 0; addrQ.delete(); prevWrite = pmem_write_o;
    for (int k = 0; k < 40; k++) begin
      driveCycle(reloads == 0, 0, 1, 32'h1357_9BDF, lineB, ld);
      if (ld) reloads++;
      if (pmem_write_o && !prevWrite) addrQ.push_back(pmem_address_o);
      prevWrite = pmem_write_o;
      if (ewb_empty_o) emptyCnt++;
    end
    checkOutput("b2bBursts", 64'(addrQ.size()), 64'd2);
    checkOutput("b2bAddr0", 64'((addrQ.size() > 0) ? addrQ[0] : 32'hx), 64'hABCD_0040);
    checkOutput("b2bAddr1", 64'((addrQ.size() > 1) ? addrQ[1] : 32'hx), 64'h1357_9BC0);
    checkOutput("b2bEmptyPulses", 64'(emptyCnt), 64'd2);

    // Randomized traffic against the model
    applyStimulus(1500, 30, 25, 60);
    applyStimulus(500, 60, 5, 90);

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
